// File: rtl/hclockdiv_multi_if.sv
// Control and status bundle for hclockdiv_multi.
//   ien       per-channel run enable (level)
//   iresync   1-cycle pulse: phase-align all running channels
//   idiv_wr   1-cycle write strobe for a half-period value
//   idiv_sel  channel index for the write
//   idiv_val  new half-period in iclk cycles (0 is ignored)
//   oclk      divided clocks, registered
//   otick     1-cycle pulse on each oclk 0->1 transition
//   orunning  channel is not idle
interface hclockdiv_multi_if #(
  parameter int NCH = 4,
  parameter int W   = 32,
  parameter int SW  = (NCH > 1) ? $clog2(NCH) : 1
);
  logic [NCH-1:0] ien;
  logic           iresync;
  logic           idiv_wr;
  logic [SW-1:0]  idiv_sel;
  logic [W-1:0]   idiv_val;
  logic [NCH-1:0] oclk;
  logic [NCH-1:0] otick;
  logic [NCH-1:0] orunning;

  modport master (output ien, iresync, idiv_wr, idiv_sel, idiv_val,
                  input  oclk, otick, orunning);
  modport slave  (input  ien, iresync, idiv_wr, idiv_sel, idiv_val,
                  output oclk, otick, orunning);
endinterface

// File: rtl/hclockdiv_multi.sv
// N-channel programmable 50%-duty clock divider with per-channel tick.
//   iclk, irst_n  system clock, synchronous active-low reset
//   bus           hclockdiv_multi_if slave (enables, resync, write port, outputs)
// Each channel counts iclk cycles up to its active half-period and toggles.
// The active half-period only reloads from pending at a toggle, at enable or
// on resync, so a half-phase never mixes two values.

// One divider channel. wr is already decoded (channel hit, nonzero value).
module hclockdiv_ch #(
  parameter int W            = 32,
  parameter int DEFAULT_HALF = 250000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         resync,
  input  logic         wr,
  input  logic [W-1:0] val,
  output logic         div_clk,
  output logic         tick,
  output logic         running
);
  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  state_t       state, state_n;
  logic [W-1:0] count, count_n, active, active_n, pending, pending_n;
  logic         lvl, lvl_n, tick_n;
  logic         last;

  assign last = (count == active - W'(1));

  always_comb begin
    state_n   = state;
    count_n   = count;
    active_n  = active;
    lvl_n     = lvl;
    tick_n    = 1'b0;
    pending_n = wr ? val : pending;
    case (state)
      IDLE: begin
        if (en) begin
          state_n  = RUN;
          count_n  = '0;
          lvl_n    = 1'b0;
          active_n = pending;
        end
      end
      default: begin
        if (resync) begin
          // Resync wins over toggle and stop; a stopping channel just ends.
          count_n  = '0;
          lvl_n    = 1'b0;
          active_n = pending;
          if (state == STOPPING) state_n = IDLE;
        end else if (!en && !lvl) begin
          // Low phase: stopping now cannot produce a runt pulse.
          state_n = IDLE;
          count_n = '0;
        end else if (last) begin
          count_n  = '0;
          lvl_n    = ~lvl;
          active_n = pending;  // old pending if a write lands on this edge
          tick_n   = ~lvl;
          state_n  = (!en && lvl) ? IDLE : RUN;
        end else begin
          count_n = count + W'(1);
          state_n = en ? RUN : STOPPING;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      count   <= '0;
      active  <= W'(DEFAULT_HALF);
      pending <= W'(DEFAULT_HALF);
      lvl     <= 1'b0;
      tick    <= 1'b0;
    end else begin
      state   <= state_n;
      count   <= count_n;
      active  <= active_n;
      pending <= pending_n;
      lvl     <= lvl_n;
      tick    <= tick_n;
    end
  end

  assign div_clk = lvl;
  assign running = (state != IDLE);
endmodule

module hclockdiv_multi #(
  parameter int NCH          = 4,
  parameter int W            = 32,
  parameter int DEFAULT_HALF = 250000
) (
  input  logic              iclk,
  input  logic              irst_n,
  hclockdiv_multi_if.slave  bus
);
  localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0] wr_hit;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    // Out-of-range selects match no channel; zero half-periods are dropped.
    assign wr_hit[c] = bus.idiv_wr && (bus.idiv_val != '0) &&
                       (bus.idiv_sel == SW'(c));

    hclockdiv_ch #(.W(W), .DEFAULT_HALF(DEFAULT_HALF)) u_ch (
      .clk     (iclk),
      .rst_n   (irst_n),
      .en      (bus.ien[c]),
      .resync  (bus.iresync),
      .wr      (wr_hit[c]),
      .val     (bus.idiv_val),
      .div_clk (bus.oclk[c]),
      .tick    (bus.otick[c]),
      .running (bus.orunning[c])
    );
  end
endmodule
